tdm_demux_1to4: RTL and testbench

//  Receive-side 1-to-4 time-division demultiplexer. It is the far end of a 4-to-1 mux link.
//  The transmitter drives channel i0..i3 onto one shared line in slot order 0,1,2,3,

---
 rtl/tdm_demux_1to4.sv | 152 +++++++++++++++
 tb/tb_tdm_demux_1to4.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4
//   Receive-side 1-to-4 time-division demultiplexer. Aligns to the frame-sync
//   flag that marks slot 0 and tracks the slot number of the next expected
//   beat. It collects slots 0..2 in shadow registers and publishes all four
//   channels together, as one registered frame, on the slot-3 beat.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   din          serial TDM data beat (WIDTH bits)
//   din_valid    din/frame_sync are only sampled when 1
//   frame_sync   marks the beat carrying slot 0
//   ch0..ch3     demultiplexed channel samples, registered
//   frame_valid  1-cycle pulse when ch0..ch3 take a new complete frame
//   slot         slot number of the next expected beat (0 when not locked)
//   locked       1 while aligned to the incoming frame
//   sync_err     1-cycle pulse on a sync violation
module tdm_demux_1to4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] sh0_q, sh1_q, sh2_q;
    logic [WIDTH-1:0] sh0_d, sh1_d, sh2_d;
    logic [WIDTH-1:0] ch0_q, ch1_q, ch2_q, ch3_q;
    logic [WIDTH-1:0] ch0_d, ch1_d, ch2_d, ch3_d;
    logic             fv_q, fv_d;
    logic             err_q, err_d;

    // Next-state / datapath decode
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        ch0_d   = ch0_q;
        ch1_d   = ch1_q;
        ch2_d   = ch2_q;
        ch3_d   = ch3_q;
        fv_d    = 1'b0;
        err_d   = 1'b0;

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    // Unsynced beats while hunting are silently discarded.
                    if (frame_sync) begin
                        sh0_d   = din;
                        slot_d  = 2'd1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (slot_q == 2'd0) begin
                        if (frame_sync) begin
                            sh0_d  = din;
                            slot_d = 2'd1;
                        end else begin
                            // Missing sync: alignment is lost, start hunting again.
                            err_d   = 1'b1;
                            slot_d  = 2'd0;
                            state_d = HUNT;
                        end
                    end else if (frame_sync) begin
                        // Early sync: abandon the partial frame and restart it
                        // with this beat as slot 0; published channels hold.
                        err_d  = 1'b1;
                        sh0_d  = din;
                        slot_d = 2'd1;
                    end else begin
                        case (slot_q)
                            2'd1:    sh1_d = din;
                            2'd2:    sh2_d = din;
                            default: begin
                                ch0_d = sh0_q;
                                ch1_d = sh1_q;
                                ch2_d = sh2_q;
                                ch3_d = din;
                                fv_d  = 1'b1;
                            end
                        endcase
                        slot_d = slot_q + 2'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = 2'd0;
                end
            endcase
        end
    end

    // Register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            slot_q  <= 2'd0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            ch0_q   <= '0;
            ch1_q   <= '0;
            ch2_q   <= '0;
            ch3_q   <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            ch0_q   <= ch0_d;
            ch1_q   <= ch1_d;
            ch2_q   <= ch2_d;
            ch3_q   <= ch3_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
        end
    end

    assign ch0         = ch0_q;
    assign ch1         = ch1_q;
    assign ch2         = ch2_q;
    assign ch3         = ch3_q;
    assign frame_valid = fv_q;
    assign sync_err    = err_q;
    assign slot        = slot_q;
    assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1to4.sv
module tb_tdm_demux_1to4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         frame_sync = 1'b0;
    logic [W-1:0] ch0, ch1, ch2, ch3;
    logic         frame_valid;
    logic [1:0]   slot;
    logic         locked;
    logic         sync_err;

    int tests = 0;
    int fails = 0;

    tdm_demux_1to4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .ch0         (ch0),
        .ch1         (ch1),
        .ch2         (ch2),
        .ch3         (ch3),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    wire [15:0] chs = {ch0, ch1, ch2, ch3};
    // {frame_valid, sync_err, locked, slot}
    wire [4:0]  st  = {frame_valid, sync_err, locked, slot};

    // Drive one valid beat, then sample 1 time unit after the capturing edge.
    task automatic send(input logic [W-1:0] d, input logic s);
        @(negedge clk);
        din        = d;
        din_valid  = 1'b1;
        frame_sync = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        din        = 4'hF;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        din_valid = 1'b0;
        rst_n     = 1'b0;
        #2;
        rst_n = 1'b1 ^ 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++;
        if (chs !== 16'h0000 || st !== 5'b00000) begin
            fails++;
            $display("FAIL reset: chs=%h st=%b expected chs=0000 st=00000", chs, st);
        end
    endtask

    task automatic test_basic_frame();
        send(4'hA, 1'b1);
        tests++;
        if (st !== 5'b00101) begin
            fails++;
            $display("FAIL basic_lock: st=%b expected 00101", st);
        end
        send(4'hB, 1'b0);
        send(4'hC, 1'b0);
        tests++;
        if (st !== 5'b00111) begin
            fails++;
            $display("FAIL basic_slot3: st=%b expected 00111", st);
        end
        send(4'hD, 1'b0);
        tests++;
        if (st !== 5'b10100 || chs !== 16'hABCD) begin
            fails++;
            $display("FAIL basic_frame: st=%b chs=%h expected st=10100 chs=ABCD", st, chs);
        end
        idle();
        tests++;
        if (st !== 5'b00100 || chs !== 16'hABCD) begin
            fails++;
            $display("FAIL basic_hold: st=%b chs=%h expected st=00100 chs=ABCD", st, chs);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int pulse_at [2];
        for (int i = 1; i <= 8; i++) begin
            send(i[3:0], (i == 1) || (i == 5));
            if (frame_valid === 1'b1) begin
                if (pulses < 2) pulse_at[pulses] = i;
                pulses++;
            end
            if (i == 4) begin
                tests++;
                if (chs !== 16'h1234) begin
                    fails++;
                    $display("FAIL b2b_first: chs=%h expected 1234", chs);
                end
            end
        end
        tests++;
        if (pulses != 2 || pulse_at[0] != 4 || pulse_at[1] != 8) begin
            fails++;
            $display("FAIL b2b_pulses: count=%0d at %0d,%0d expected 2 at 4,8",
                     pulses, pulse_at[0], pulse_at[1]);
        end
        tests++;
        if (chs !== 16'h5678 || sync_err !== 1'b0) begin
            fails++;
            $display("FAIL b2b_data: chs=%h err=%b expected 5678 err=0", chs, sync_err);
        end
    endtask

    task automatic test_hunt_discard();
        int errs = 0;
        do_reset();
        send(4'h1, 1'b0);
        if (sync_err !== 1'b0) errs++;
        send(4'h2, 1'b0);
        if (sync_err !== 1'b0) errs++;
        send(4'h3, 1'b0);
        if (sync_err !== 1'b0) errs++;
        tests++;
        if (errs != 0 || st !== 5'b00000) begin
            fails++;
            $display("FAIL hunt_discard: errs=%0d st=%b expected 0 st=00000", errs, st);
        end
        send(4'h9, 1'b1);
        send(4'hA, 1'b0);
        send(4'hB, 1'b0);
        send(4'hC, 1'b0);
        tests++;
        if (st !== 5'b10100 || chs !== 16'h9ABC) begin
            fails++;
            $display("FAIL hunt_frame: st=%b chs=%h expected st=10100 chs=9ABC", st, chs);
        end
    endtask

    task automatic test_early_sync();
        send(4'h1, 1'b1);
        send(4'h2, 1'b0);
        send(4'h3, 1'b1);
        tests++;
        if (st !== 5'b01101 || chs !== 16'h9ABC) begin
            fails++;
            $display("FAIL early_sync: st=%b chs=%h expected st=01101 chs=9ABC", st, chs);
        end
        send(4'h4, 1'b0);
        tests++;
        if (st !== 5'b00110) begin
            fails++;
            $display("FAIL early_clear: st=%b expected 00110", st);
        end
        send(4'h5, 1'b0);
        send(4'h6, 1'b0);
        tests++;
        if (st !== 5'b10100 || chs !== 16'h3456) begin
            fails++;
            $display("FAIL early_frame: st=%b chs=%h expected st=10100 chs=3456", st, chs);
        end
    endtask

    task automatic test_missing_sync();
        send(4'h7, 1'b0);
        tests++;
        if (st !== 5'b01000 || chs !== 16'h3456) begin
            fails++;
            $display("FAIL missing_sync: st=%b chs=%h expected st=01000 chs=3456", st, chs);
        end
        idle();
        tests++;
        if (st !== 5'b00000) begin
            fails++;
            $display("FAIL missing_clear: st=%b expected 00000", st);
        end
    endtask

    task automatic test_reset_midframe();
        int pulses = 0;
        send(4'h1, 1'b1);
        send(4'h2, 1'b0);
        @(negedge clk);
        din_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        tests++;
        if (chs !== 16'h0000 || st !== 5'b00000) begin
            fails++;
            $display("FAIL midreset_out: chs=%h st=%b expected 0000 00000", chs, st);
        end
        @(posedge clk);
        #1;
        tests++;
        if (chs !== 16'h0000 || st !== 5'b00000) begin
            fails++;
            $display("FAIL midreset_hold: chs=%h st=%b expected 0000 00000", chs, st);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // New frame with gaps inside it; only its own data may appear.
        send(4'hE, 1'b1);
        if (frame_valid === 1'b1) pulses++;
        idle();
        if (frame_valid === 1'b1) pulses++;
        tests++;
        if (st !== 5'b00101) begin
            fails++;
            $display("FAIL gap_hold: st=%b expected 00101", st);
        end
        send(4'hF, 1'b0);
        if (frame_valid === 1'b1) pulses++;
        idle();
        if (frame_valid === 1'b1) pulses++;
        idle();
        if (frame_valid === 1'b1) pulses++;
        send(4'h0, 1'b0);
        if (frame_valid === 1'b1) pulses++;
        send(4'h1, 1'b0);
        if (frame_valid === 1'b1) pulses++;
        tests++;
        if (chs !== 16'hEF01 || st !== 5'b10100) begin
            fails++;
            $display("FAIL gap_frame: chs=%h st=%b expected EF01 10100", chs, st);
        end
        idle();
        if (frame_valid === 1'b1) pulses++;
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL midreset_pulses: got %0d expected 1", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_hunt_discard();
        test_early_sync();
        test_missing_sync();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
